// File: rtl/interpol_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : interpol_pkg
//  Brief    : Shared widths, limits and FSM encodings for the CIC
//             interpolator scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package interpol_pkg;

    // Sample widths presented to the interpolator
    localparam int DY_W       = 17;
    localparam int DY7_W      = 18;

    // Smallest period_cfg honoured at runtime; smaller values select the default
    localparam int MIN_PERIOD = 2;

    // Scheduler states; encoding is visible on the status port
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALIGN   = 2'd1,
        ST_RUN     = 2'd2,
        ST_RECOVER = 2'd3
    } sched_state_t;

endpackage : interpol_pkg
`default_nettype wire

// File: rtl/strobe_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : strobe_cnt
//  Brief    : Phase down-counter for the interpolator scheduler. Loads a
//             start value, counts down while run is high and flags the
//             terminal count (phase == 0) on wrap.
//  Revision : 1.0  initial release
// ============================================================================
module strobe_cnt #(
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic [CNTW-1:0] load_val,
    input  logic            run,
    output logic [CNTW-1:0] phase,
    output logic            wrap
);

    logic [CNTW-1:0] r_phase;

    // Counter register: clear beats load beats decrement; stops at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if (clr) begin
            r_phase <= '0;
        end else if (load) begin
            r_phase <= load_val;
        end else if (run && (r_phase != '0)) begin
            r_phase <= r_phase - CNTW'(1);
        end
    end

    assign phase = r_phase;
    assign wrap  = (r_phase == '0);

endmodule : strobe_cnt
`default_nettype wire

// File: rtl/interpol_sched.sv
`default_nettype none
// ============================================================================
//  Module   : interpol_sched
//  Brief    : Strobe scheduler for the CIC interpolator. Generates a
//             periodic one-cycle strobe, feeds buffered (dy, dy7) pairs on
//             each strobe, aligns phase to an external sync pulse and backs
//             off for one period after a timing error.
//  Revision : 1.0  initial release
// ============================================================================
module interpol_sched
    import interpol_pkg::*;
#(
    parameter int CNTW   = 8,
    parameter int PERIOD = 33,
    parameter int ERRW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CNTW-1:0]   period_cfg,
    input  logic              sync,
    input  logic              in_valid,
    input  logic [DY_W-1:0]   in_dy,
    input  logic [DY7_W-1:0]  in_dy7,
    output logic              in_ready,
    input  logic              timing_error,
    input  logic              clear,
    output logic              strobe,
    output logic [DY_W-1:0]   dy,
    output logic [DY7_W-1:0]  dy7,
    output logic [CNTW-1:0]   phase,
    output logic [1:0]        state,
    output logic              underrun,
    output logic              overrun,
    output logic              slip,
    output logic [ERRW-1:0]   err_count
);

    localparam logic [CNTW-1:0] c_default_period = CNTW'(PERIOD);
    localparam logic [CNTW-1:0] c_min_period     = CNTW'(MIN_PERIOD);

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic [CNTW-1:0]  r_period_eff;
    logic [CNTW-1:0]  w_period_sel;
    logic [CNTW-1:0]  w_load_val;
    logic [CNTW-1:0]  w_phase;
    logic             w_at_zero;
    logic             w_cnt_clr;
    logic             w_cnt_load;
    logic             w_cnt_run;
    logic             w_period_upd;
    logic             w_wrap;
    logic             w_slip_set;

    logic             r_buf_full;
    logic [DY_W-1:0]  r_buf_dy;
    logic [DY7_W-1:0] r_buf_dy7;

    logic             r_strobe;
    logic [DY_W-1:0]  r_dy;
    logic [DY7_W-1:0] r_dy7;
    logic             r_underrun;
    logic             r_overrun;
    logic             r_slip;
    logic [ERRW-1:0]  r_err_count;

    logic             w_accept;
    logic             w_load_now;
    logic             w_in_ready;
    logic             w_push;
    logic             w_overrun_set;
    logic             w_underrun_set;

    // Period requested by software, falling back to the default when too small
    assign w_period_sel = (period_cfg < c_min_period) ? c_default_period : period_cfg;

    strobe_cnt #(
        .CNTW (CNTW)
    ) u_strobe_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_cnt_clr),
        .load     (w_cnt_load),
        .load_val (w_load_val),
        .run      (w_cnt_run),
        .phase    (w_phase),
        .wrap     (w_at_zero)
    );

    // Next-state and counter control; disable overrides every state
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_run    = 1'b0;
        w_load_val   = r_period_eff - CNTW'(1);
        w_period_upd = 1'b0;
        w_wrap       = 1'b0;
        w_slip_set   = 1'b0;
        if (!enable) begin
            w_state_next = ST_IDLE;
            w_cnt_clr    = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_ALIGN;
                end
                ST_ALIGN: begin
                    if (sync) begin
                        w_state_next = ST_RUN;
                        w_cnt_load   = 1'b1;
                        w_load_val   = w_period_sel - CNTW'(1);
                        w_period_upd = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (timing_error) begin
                        // Back off for one full period at the current rate
                        w_state_next = ST_RECOVER;
                        w_cnt_load   = 1'b1;
                    end else if (w_at_zero) begin
                        // Period boundary: the only point period_cfg is re-sampled
                        w_cnt_load   = 1'b1;
                        w_load_val   = w_period_sel - CNTW'(1);
                        w_period_upd = 1'b1;
                        w_wrap       = 1'b1;
                    end else if (sync) begin
                        // Sync off-phase: restart the period, truncated one gets no strobe
                        w_cnt_load   = 1'b1;
                        w_slip_set   = 1'b1;
                    end else begin
                        w_cnt_run    = 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (w_at_zero) begin
                        w_state_next = ST_ALIGN;
                    end else begin
                        w_cnt_run    = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Buffer handshake: a full buffer frees up in the same cycle it feeds the outputs
    assign w_accept       = enable && (r_state != ST_IDLE);
    assign w_load_now     = w_wrap && r_buf_full;
    assign w_in_ready     = w_accept && (!r_buf_full || w_load_now);
    assign w_push         = in_valid && w_in_ready;
    assign w_overrun_set  = in_valid && w_accept && !w_in_ready;
    assign w_underrun_set = w_wrap && !r_buf_full;

    // State register and effective period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_period_eff <= c_default_period;
        end else begin
            r_state <= w_state_next;
            if (w_period_upd) begin
                r_period_eff <= w_period_sel;
            end
        end
    end

    // One-deep holding buffer; flushed whenever the scheduler is idle or disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_full <= 1'b0;
            r_buf_dy   <= '0;
            r_buf_dy7  <= '0;
        end else if (!enable || (r_state == ST_IDLE)) begin
            r_buf_full <= 1'b0;
        end else if (w_push) begin
            r_buf_full <= 1'b1;
            r_buf_dy   <= in_dy;
            r_buf_dy7  <= in_dy7;
        end else if (w_load_now) begin
            r_buf_full <= 1'b0;
        end
    end

    // Strobe and sample outputs: new pair appears together with the strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe <= 1'b0;
            r_dy     <= '0;
            r_dy7    <= '0;
        end else if (!enable) begin
            r_strobe <= 1'b0;
            r_dy     <= '0;
            r_dy7    <= '0;
        end else begin
            r_strobe <= w_wrap;
            if (w_load_now) begin
                r_dy  <= r_buf_dy;
                r_dy7 <= r_buf_dy7;
            end
        end
    end

    // Sticky status flags and saturating error count; a set in the clear cycle wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun  <= 1'b0;
            r_overrun   <= 1'b0;
            r_slip      <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_underrun <= w_underrun_set || (r_underrun && !clear);
            r_overrun  <= w_overrun_set  || (r_overrun  && !clear);
            r_slip     <= w_slip_set     || (r_slip     && !clear);
            if (timing_error) begin
                if (clear) begin
                    r_err_count <= ERRW'(1);
                end else if (r_err_count != '1) begin
                    r_err_count <= r_err_count + ERRW'(1);
                end
            end else if (clear) begin
                r_err_count <= '0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign strobe    = r_strobe;
    assign dy        = r_dy;
    assign dy7       = r_dy7;
    assign phase     = w_phase;
    assign state     = r_state;
    assign underrun  = r_underrun;
    assign overrun   = r_overrun;
    assign slip      = r_slip;
    assign err_count = r_err_count;

endmodule : interpol_sched
`default_nettype wire
